// File: rtl/pwm_step_sequencer.sv
// pwm_step_sequencer: plays a programmable duty table into the PWM generator, one entry per step.
// Optional SEQ_LENGTH_EN adds a seq_len input that shortens the playback loop.
module pwm_step_sequencer #(
    parameter int PWM_INTERVAL   = 1200,
    parameter int NUM_STEPS      = 8,
    parameter int STEP_INTERVALS = 2500,
    localparam int VW = $clog2(PWM_INTERVAL),
    localparam int AW = $clog2(NUM_STEPS),
    localparam int SW = STEP_INTERVALS > 1 ? $clog2(STEP_INTERVALS) : 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef SEQ_LENGTH_EN
    input  logic [AW:0]   seq_len,
`endif
    input  logic          run,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [VW-1:0] wr_data,
    output logic [VW-1:0] pwm_value,
    output logic [AW-1:0] step_idx,
    output logic          step_tick,
    output logic          running
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [VW-1:0] tbl_q [NUM_STEPS];
    logic [VW-1:0] tbl_d [NUM_STEPS];
    logic [VW-1:0] icnt_q, icnt_d, pwm_value_q, pwm_value_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [AW-1:0] step_idx_q, step_idx_d, nxt_idx;
    logic          step_tick_q, step_tick_d;
    logic          boundary, step_end;
    assign boundary = icnt_q == VW'(PWM_INTERVAL - 1);
    assign step_end = boundary && scnt_q == SW'(STEP_INTERVALS - 1);
`ifdef SEQ_LENGTH_EN
    logic [AW:0] len;
    assign len     = (seq_len == '0 || seq_len > (AW+1)'(NUM_STEPS)) ? (AW+1)'(NUM_STEPS) : seq_len;
    assign nxt_idx = ({1'b0, step_idx_q} + 1'b1 >= len) ? '0 : step_idx_q + 1'b1;
`else
    assign nxt_idx = step_idx_q + 1'b1;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (run ? RUN : IDLE) : ((boundary && !run) ? IDLE : RUN);
    end
    // Table reads use tbl_q, so a same-cycle write to the loaded entry is not seen.
    always_comb begin
        tbl_d = tbl_q;
        if (wr_en) tbl_d[wr_addr] = wr_data;
        icnt_d      = '0;
        scnt_d      = '0;
        pwm_value_d = pwm_value_q;
        step_idx_d  = step_idx_q;
        step_tick_d = 1'b0;
        if (state_q == RUN) begin
            if (boundary && !run) begin
                pwm_value_d = '0;
                step_idx_d  = '0;
            end else begin
                icnt_d = boundary ? '0 : icnt_q + 1'b1;
                scnt_d = boundary ? (step_end ? '0 : scnt_q + 1'b1) : scnt_q;
                if (step_end) begin
                    step_idx_d  = nxt_idx;
                    pwm_value_d = tbl_q[nxt_idx];
                    step_tick_d = 1'b1;
                end
            end
        end else if (run) begin
            pwm_value_d = tbl_q[0];
            step_idx_d  = '0;
            step_tick_d = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_q       <= '{default: '0};
            icnt_q      <= '0;
            scnt_q      <= '0;
            pwm_value_q <= '0;
            step_idx_q  <= '0;
            step_tick_q <= 1'b0;
        end else begin
            tbl_q       <= tbl_d;
            icnt_q      <= icnt_d;
            scnt_q      <= scnt_d;
            pwm_value_q <= pwm_value_d;
            step_idx_q  <= step_idx_d;
            step_tick_q <= step_tick_d;
        end
    end
    assign pwm_value = pwm_value_q;
    assign step_idx  = step_idx_q;
    assign step_tick = step_tick_q;
    assign running   = state_q == RUN;
endmodule

// File: tb/tb_pwm_step_sequencer.sv
// tb_pwm_step_sequencer: directed plan plus random run/write traffic against a step-phase reference model.
module tb_pwm_step_sequencer;
    localparam int PI = 10, NS = 4, SI = 3;
    logic clk = 0, rst = 1, run = 0, wr_en = 0;
    logic [1:0] wr_addr = 0;
    logic [3:0] wr_data = 0;
`ifdef SEQ_LENGTH_EN
    logic [2:0] seq_len = 0;
`endif
    logic [3:0] pwm_value;
    logic [1:0] step_idx;
    logic       step_tick, running;
    int total = 0, bad = 0;
    bit m_run, m_tick;
    int m_ph, m_idx, m_val;
    int m_tbl [NS];

    always #5 clk = ~clk;

    pwm_step_sequencer #(.PWM_INTERVAL(PI), .NUM_STEPS(NS), .STEP_INTERVALS(SI)) dut (
        .clk(clk), .rst(rst),
`ifdef SEQ_LENGTH_EN
        .seq_len(seq_len),
`endif
        .run(run), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pwm_value(pwm_value), .step_idx(step_idx), .step_tick(step_tick), .running(running)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_ph = 0; m_idx = 0; m_val = 0; m_tick = 0;
        foreach (m_tbl[i]) m_tbl[i] = 0;
    endtask

    // m_ph is the cycle position inside the current step, 0..PI*SI-1
    task automatic model_edge();
        int len;
        len = NS;
`ifdef SEQ_LENGTH_EN
        if (seq_len != 0 && seq_len <= NS) len = int'(seq_len);
`endif
        m_tick = 0;
        if (!m_run) begin
            if (run) begin m_run = 1; m_ph = 0; m_idx = 0; m_val = m_tbl[0]; m_tick = 1; end
        end else if (m_ph % PI == PI - 1 && !run) begin
            m_run = 0; m_ph = 0; m_idx = 0; m_val = 0;
        end else if (m_ph == PI * SI - 1) begin
            m_ph = 0; m_idx = (m_idx + 1 >= len) ? 0 : m_idx + 1; m_val = m_tbl[m_idx]; m_tick = 1;
        end else m_ph++;
        if (wr_en) m_tbl[wr_addr] = int'(wr_data);
    endtask

    task automatic cyc(input bit r, input bit we = 0, input int a = 0, input int d = 0);
        run = r; wr_en = we; wr_addr = 2'(a); wr_data = 4'(d);
        @(posedge clk);
        model_edge();
        #1;
        check("pwm_value", pwm_value, m_val);
        check("step_idx", step_idx, m_idx);
        check("step_tick", step_tick, m_tick);
        check("running", running, m_run);
    endtask

    task automatic steps(input int n);
        repeat (n) cyc(1);
    endtask

    initial begin
        model_reset();
        #2;
        check("rst_pwm", pwm_value, 0);
        check("rst_idx", step_idx, 0);
        check("rst_running", running, 0);
        check("rst_tick", step_tick, 0);
        #10 rst = 0;
        // 1: basic playback
        cyc(0, 1, 0, 3); cyc(0, 1, 1, 5); cyc(0, 1, 2, 7); cyc(0, 1, 3, 9);
        check("t1_idle_pwm", pwm_value, 0);
        cyc(1);
        check("t1_first", pwm_value, 3);
        check("t1_first_tick", step_tick, 1);
        steps(29);
        check("t1_no_tick", step_tick, 0);
        cyc(1);
        check("t1_step1", pwm_value, 5);
        steps(30); check("t1_step2", pwm_value, 7);
        steps(30); check("t1_step3", pwm_value, 9);
        steps(30); check("t1_wrap_pwm", pwm_value, 3); check("t1_wrap_idx", step_idx, 0);
        steps(30); check("t2_step1", pwm_value, 5);
        // 2: drop run mid-interval, stop at boundary
        steps(4);
        repeat (5) cyc(0);
        check("t2_hold_pwm", pwm_value, 5);
        check("t2_hold_running", running, 1);
        cyc(0);
        check("t2_idle_pwm", pwm_value, 0);
        check("t2_idle_running", running, 0);
        repeat (3) cyc(0);
        // 3: short run glitch inside an interval
        cyc(1); steps(2);
        repeat (4) cyc(0);
        steps(23);
        check("t3_pre", pwm_value, 3);
        cyc(1);
        check("t3_step1", pwm_value, 5);
        steps(30); check("t3_step2", pwm_value, 7);
        // 4: writes during step 2
        steps(5); cyc(1, 1, 2, 1); steps(23);
        check("t4_hold", pwm_value, 7);
        cyc(1, 1, 3, 8);
        check("t4_old9", pwm_value, 9);
        steps(30); check("t4_lap0", pwm_value, 3);
        steps(30); check("t4_lap1", pwm_value, 5);
        steps(30); check("t4_new1", pwm_value, 1);
        steps(30); check("t4_new8", pwm_value, 8);
        // 5: asynchronous reset mid-step
        steps(7);
        #2 rst = 1;
        #1;
        model_reset();
        check("t5_pwm", pwm_value, 0);
        check("t5_idx", step_idx, 0);
        check("t5_running", running, 0);
        @(posedge clk);
        #2 rst = 0;
        cyc(1);
        check("t5_restart_pwm", pwm_value, 0);
        check("t5_restart_tick", step_tick, 1);
        cyc(1, 1, 1, 12); steps(28); cyc(1);
        check("t5_unclamped", pwm_value, 12);
`ifdef SEQ_LENGTH_EN
        // 6: programmable loop length
        repeat (2) cyc(0);
        repeat (10) cyc(0);
        cyc(0, 1, 0, 3); cyc(0, 1, 1, 5); cyc(0, 1, 2, 7); cyc(0, 1, 3, 9);
        seq_len = 2;
        cyc(1); check("t6_s0", step_idx, 0);
        steps(30); check("t6_s1", step_idx, 1);
        steps(30); check("t6_s0b", step_idx, 0);
        steps(30); check("t6_s1b", step_idx, 1);
        seq_len = 0;
        steps(30); check("t6_full2", step_idx, 2);
        steps(30); check("t6_full3", step_idx, 3);
        seq_len = 1;
        steps(30); check("t6_one_a", step_idx, 0);
        steps(30); check("t6_one_b", step_idx, 0); check("t6_one_tick", step_tick, 1);
`endif
        // random traffic
        repeat (1500) begin
`ifdef SEQ_LENGTH_EN
            if ($urandom_range(0, 99) == 0) seq_len = 3'($urandom_range(0, 7));
`endif
            cyc($urandom_range(0, 24) != 0, $urandom_range(0, 7) == 0,
                int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 15)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
